addr_reg_unit: RTL and testbench
================================

ADDR_REG_UNIT -- requirements
Module: addr_reg_unit

Interface
REQ-001 Parameter ADDR_W, default 16, address width in bits.
REQ-002 Parameter STEP, default 1, increment/decrement amount, range 1..2^ADDR_W-1.
REQ-003 Parameter WRAP_EN, default 1; 1 = modulo wrap, 0 = saturate at 0 / 2^ADDR_W-1.
REQ-004 Parameter RST_ADDR, default 0, address value loaded on reset.
REQ-005 Parameter BURST_W, default 4, width of burst length field.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 bus_addr  input  ADDR_W  address presented by system bus.
REQ-009 MAR_En  input  1  load strobe; captures bus_addr.
REQ-010 inc_en  input  1  add STEP to address.
REQ-011 dec_en  input  1  subtract STEP from address.
REQ-012 burst_start  input  1  request auto-increment burst.
REQ-013 burst_len  input  BURST_W  number of beats; sampled with burst_start.
REQ-014 mem_ready  input  1  memory accepted current beat.
REQ-015 addr_out  output  ADDR_W  registered current address.
REQ-016 addr_valid  output  1  high in BURST state; beat offered.
REQ-017 burst_busy  output  1  high in BURST or DONE.
REQ-018 burst_done  output  1  one-cycle pulse in DONE.
REQ-019 ovf  output  1  sticky wrap/saturation flag.

Function
REQ-020 All outputs registered; any command affects addr_out one clk edge later.
REQ-021 Per-edge priority: MAR_En > active burst beat > inc_en/dec_en > hold.
REQ-022 MAR_En: addr_out <= bus_addr, ovf <= 0; if in BURST/DONE, state -> IDLE with no burst_done pulse (abort).
REQ-023 inc_en and dec_en both high, IDLE: address held, ovf unchanged.
REQ-024 inc_en/dec_en ignored while burst_busy.
REQ-025 Increment crossing 2^ADDR_W-1: WRAP_EN=1 -> (addr+STEP) mod 2^ADDR_W; WRAP_EN=0 -> 2^ADDR_W-1; ovf <= 1 in both.
REQ-026 Decrement below 0: WRAP_EN=1 -> modulo result; WRAP_EN=0 -> 0; ovf <= 1 in both.
REQ-027 ovf cleared only by rst or MAR_En; otherwise stays 1 once set.
REQ-028 FSM states IDLE, BURST, DONE; encoding free.
REQ-029 IDLE -> BURST: burst_start=1, burst_len!=0, MAR_En=0; beat counter <= burst_len.
REQ-030 burst_start with burst_len=0: ignored, stay IDLE, no pulse.
REQ-031 burst_start in BURST or DONE ignored.
REQ-032 BURST: addr_valid=1; each edge with mem_ready=1 -> address += STEP (REQ-025 rules), counter -= 1; mem_ready=0 -> hold everything.
REQ-033 BURST -> DONE on the accepted beat where counter==1; addr_out then points one STEP past the last beat.
REQ-034 DONE lasts exactly one cycle: burst_done=1, addr_valid=0; then IDLE.
REQ-035 burst_busy = (state==BURST)||(state==DONE).
REQ-036 Wrap/saturation during a burst sets ovf; burst continues until counter expires.

Reset
REQ-037 rst=1 immediately (no clock) forces: addr_out=RST_ADDR, state=IDLE, counter=0, addr_valid=0, burst_busy=0, burst_done=0, ovf=0.
REQ-038 Reset mid-burst abandons the burst without a burst_done pulse.
REQ-039 On rst deassertion, first edge obeys normal priority; no spurious command.

Verification
REQ-040 Load: bus_addr=16'h00CF, MAR_En pulse -> addr_out=16'h00CF next edge, ovf=0; rst mid-cycle -> addr_out=16'h0000 without clk edge.
REQ-041 Wrap: load 16'hFFFF, inc_en one cycle, WRAP_EN=1 -> addr_out=16'h0000, ovf=1; WRAP_EN=0 build -> 16'hFFFF, ovf=1; next MAR_En clears ovf.
REQ-042 Burst: load 16'h00AD, burst_start, burst_len=3, mem_ready=1 -> addr_out 00AD,00AE,00AF with addr_valid=1, then 00B0 with burst_done=1 one cycle, then IDLE.
REQ-043 Stall/abort: burst_len=4, mem_ready toggled 1,0,1 -> address advances only on ready cycles; MAR_En mid-burst with bus_addr=16'h1234 -> addr_out=16'h1234, IDLE, burst_done never asserted.
REQ-044 Corner commands: inc_en&dec_en together -> hold; burst_len=0 -> no state change; inc_en during burst -> ignored; dec_en at 16'h0000, WRAP_EN=1 -> 16'hFFFF, ovf=1.

Source files
------------

// File: rtl/addr_reg_unit.sv
// -----------------------------------------------------------------------------
// addr_reg_unit
//
// Purpose:
//   Memory address register (MAR) with load, step increment/decrement,
//   wrap-or-saturate overflow handling and a small auto-increment burst
//   engine (IDLE -> BURST -> DONE -> IDLE).
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   bus_addr     in   [ADDR_W]  address presented by the system bus
//   MAR_En       in   load strobe, captures bus_addr (highest priority)
//   inc_en       in   add STEP (IDLE only)
//   dec_en       in   subtract STEP (IDLE only)
//   burst_start  in   request an auto-increment burst
//   burst_len    in   [BURST_W] beat count, sampled with burst_start
//   mem_ready    in   memory accepted the current beat
//   addr_out     out  [ADDR_W]  registered current address
//   addr_valid   out  beat offered (BURST state)
//   burst_busy   out  BURST or DONE
//   burst_done   out  one-cycle pulse in DONE
//   ovf          out  sticky wrap/saturation flag
// -----------------------------------------------------------------------------
module addr_reg_unit #(
  parameter int ADDR_W   = 16,
  parameter int STEP     = 1,
  parameter int WRAP_EN  = 1,
  parameter int RST_ADDR = 0,
  parameter int BURST_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              MAR_En,
  input  logic              inc_en,
  input  logic              dec_en,
  input  logic              burst_start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  output logic              burst_busy,
  output logic              burst_done,
  output logic              ovf
);

  localparam logic [ADDR_W-1:0]  STEP_V = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0]  RST_V  = ADDR_W'(RST_ADDR);
  localparam logic [BURST_W-1:0] ONE_B  = BURST_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  // Returns {overflow_flag, next_address}. The extra MSB of the widened sum
  // is the carry; in saturating builds a carry pins the result to all-ones.
  function automatic logic [ADDR_W:0] step_up(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, STEP_V};
    if (s[ADDR_W] && (WRAP_EN == 0)) begin
      step_up = {1'b1, {ADDR_W{1'b1}}};
    end else begin
      step_up = s;
    end
  endfunction

  // Returns {underflow_flag, next_address}. The widened difference's MSB is
  // the borrow; in saturating builds a borrow pins the result to zero.
  function automatic logic [ADDR_W:0] step_down(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] d;
    d = {1'b0, a} - {1'b0, STEP_V};
    if (d[ADDR_W] && (WRAP_EN == 0)) begin
      step_down = {1'b1, {ADDR_W{1'b0}}};
    end else begin
      step_down = d;
    end
  endfunction

  logic [ADDR_W:0] up_r, dn_r;

  always_comb begin
    up_r = step_up(addr_q);
    dn_r = step_down(addr_q);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (MAR_En) begin
      // Load wins over everything and aborts any burst silently.
      addr_d  = bus_addr;
      ovf_d   = 1'b0;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (burst_start && (burst_len != '0)) begin
            state_d = S_BURST;
            cnt_d   = burst_len;
          end
          // Both strobes together cancel out: address and flag hold.
          if (inc_en && !dec_en) begin
            addr_d = up_r[ADDR_W-1:0];
            ovf_d  = ovf_q | up_r[ADDR_W];
          end else if (dec_en && !inc_en) begin
            addr_d = dn_r[ADDR_W-1:0];
            ovf_d  = ovf_q | dn_r[ADDR_W];
          end
        end
        S_BURST: begin
          if (mem_ready) begin
            addr_d = up_r[ADDR_W-1:0];
            ovf_d  = ovf_q | up_r[ADDR_W];
            cnt_d  = cnt_q - ONE_B;
            if (cnt_q == ONE_B) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= RST_V;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status outputs are pure decodes of registered state, so they change
  // only on a clock edge or on reset.
  assign addr_out   = addr_q;
  assign ovf        = ovf_q;
  assign addr_valid = (state_q == S_BURST);
  assign burst_busy = (state_q == S_BURST) || (state_q == S_DONE);
  assign burst_done = (state_q == S_DONE);

endmodule

// File: tb/tb_addr_reg_unit.sv
// -----------------------------------------------------------------------------
// tb_addr_reg_unit
//
// Purpose:
//   Directed bench for addr_reg_unit. Two instances share the stimulus: one
//   wrapping build (WRAP_EN=1) and one saturating build (WRAP_EN=0).
// -----------------------------------------------------------------------------
module tb_addr_reg_unit;

  logic        clk;
  logic        rst;
  logic [15:0] bus_addr;
  logic        MAR_En;
  logic        inc_en;
  logic        dec_en;
  logic        burst_start;
  logic [3:0]  burst_len;
  logic        mem_ready;

  logic [15:0] w_addr;
  logic        w_valid, w_busy, w_done, w_ovf;
  logic [15:0] s_addr;
  logic        s_valid, s_busy, s_done, s_ovf;

  int checks;
  int failures;

  addr_reg_unit #(
    .ADDR_W(16), .STEP(1), .WRAP_EN(1), .RST_ADDR(0), .BURST_W(4)
  ) u_dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .MAR_En(MAR_En),
    .inc_en(inc_en), .dec_en(dec_en), .burst_start(burst_start),
    .burst_len(burst_len), .mem_ready(mem_ready),
    .addr_out(w_addr), .addr_valid(w_valid), .burst_busy(w_busy),
    .burst_done(w_done), .ovf(w_ovf)
  );

  addr_reg_unit #(
    .ADDR_W(16), .STEP(1), .WRAP_EN(0), .RST_ADDR(0), .BURST_W(4)
  ) u_sat (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .MAR_En(MAR_En),
    .inc_en(inc_en), .dec_en(dec_en), .burst_start(burst_start),
    .burst_len(burst_len), .mem_ready(mem_ready),
    .addr_out(s_addr), .addr_valid(s_valid), .burst_busy(s_busy),
    .burst_done(s_done), .ovf(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a);
    bus_addr = a;
    MAR_En   = 1'b1;
    tick();
    MAR_En   = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus_addr = '0; MAR_En = 0; inc_en = 0; dec_en = 0;
    burst_start = 0; burst_len = '0; mem_ready = 0;

    // Reset state, before any clock edge
    #3;
    chk("rst_addr",  w_addr, 16'h0000);
    chk("rst_valid", w_valid, 1'b0);
    chk("rst_busy",  w_busy, 1'b0);
    chk("rst_done",  w_done, 1'b0);
    chk("rst_ovf",   w_ovf, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_hold", w_addr, 16'h0000);

    // Load, then asynchronous reset mid-cycle
    load(16'h00CF);
    chk("load_addr", w_addr, 16'h00CF);
    chk("load_ovf",  w_ovf, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_addr", w_addr, 16'h0000);
    #1 rst = 1'b0;

    // Increment across the top
    load(16'hFFFF);
    inc_en = 1'b1;
    tick();
    inc_en = 1'b0;
    chk("wrap_inc_addr", w_addr, 16'h0000);
    chk("wrap_inc_ovf",  w_ovf, 1'b1);
    chk("sat_inc_addr",  s_addr, 16'hFFFF);
    chk("sat_inc_ovf",   s_ovf, 1'b1);
    tick();
    chk("ovf_sticky", w_ovf, 1'b1);
    load(16'h0005);
    chk("load_clr_ovf_w", w_ovf, 1'b0);
    chk("load_clr_ovf_s", s_ovf, 1'b0);

    // Plain increment and decrement
    inc_en = 1'b1;
    tick();
    inc_en = 1'b0;
    chk("inc_addr", w_addr, 16'h0006);
    dec_en = 1'b1;
    tick();
    tick();
    dec_en = 1'b0;
    chk("dec2_addr", w_addr, 16'h0004);

    // inc and dec together hold
    inc_en = 1'b1; dec_en = 1'b1;
    tick();
    inc_en = 1'b0; dec_en = 1'b0;
    chk("incdec_hold", w_addr, 16'h0004);
    chk("incdec_ovf",  w_ovf, 1'b0);

    // Decrement below zero
    load(16'h0000);
    dec_en = 1'b1;
    tick();
    dec_en = 1'b0;
    chk("wrap_dec_addr", w_addr, 16'hFFFF);
    chk("wrap_dec_ovf",  w_ovf, 1'b1);
    chk("sat_dec_addr",  s_addr, 16'h0000);
    chk("sat_dec_ovf",   s_ovf, 1'b1);

    // Zero-length burst request is ignored
    load(16'h00AD);
    burst_start = 1'b1; burst_len = 4'd0;
    tick();
    burst_start = 1'b0;
    chk("len0_busy",  w_busy, 1'b0);
    chk("len0_valid", w_valid, 1'b0);
    chk("len0_addr",  w_addr, 16'h00AD);

    // Three-beat burst, always ready; inc_en during the burst is ignored
    burst_start = 1'b1; burst_len = 4'd3; mem_ready = 1'b1;
    tick();
    burst_start = 1'b0; inc_en = 1'b1;
    chk("b_beat0_addr",  w_addr, 16'h00AD);
    chk("b_beat0_valid", w_valid, 1'b1);
    chk("b_beat0_busy",  w_busy, 1'b1);
    chk("b_beat0_done",  w_done, 1'b0);
    tick();
    chk("b_beat1_addr",  w_addr, 16'h00AE);
    chk("b_beat1_valid", w_valid, 1'b1);
    tick();
    chk("b_beat2_addr",  w_addr, 16'h00AF);
    tick();
    chk("b_done_addr",  w_addr, 16'h00B0);
    chk("b_done_pulse", w_done, 1'b1);
    chk("b_done_valid", w_valid, 1'b0);
    chk("b_done_busy",  w_busy, 1'b1);
    tick();
    inc_en = 1'b0;
    chk("b_idle_addr", w_addr, 16'h00B0);
    chk("b_idle_done", w_done, 1'b0);
    chk("b_idle_busy", w_busy, 1'b0);

    // Stalled burst, then abort by load
    load(16'h0100);
    burst_start = 1'b1; burst_len = 4'd4; mem_ready = 1'b0;
    tick();
    burst_start = 1'b0;
    chk("st_start_addr", w_addr, 16'h0100);
    mem_ready = 1'b1;
    tick();
    chk("st_rdy1_addr", w_addr, 16'h0101);
    mem_ready = 1'b0;
    tick();
    chk("st_stall_addr",  w_addr, 16'h0101);
    chk("st_stall_valid", w_valid, 1'b1);
    mem_ready = 1'b1;
    tick();
    chk("st_rdy2_addr", w_addr, 16'h0102);
    bus_addr = 16'h1234; MAR_En = 1'b1;
    tick();
    MAR_En = 1'b0;
    chk("abort_addr",  w_addr, 16'h1234);
    chk("abort_busy",  w_busy, 1'b0);
    chk("abort_valid", w_valid, 1'b0);
    chk("abort_done",  w_done, 1'b0);
    tick();
    chk("abort_done2", w_done, 1'b0);
    chk("abort_hold",  w_addr, 16'h1234);

    // Reset mid-burst abandons it without a done pulse
    burst_start = 1'b1; burst_len = 4'd2;
    tick();
    burst_start = 1'b0;
    chk("rb_busy_pre", w_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rb_busy",  w_busy, 1'b0);
    chk("rb_done",  w_done, 1'b0);
    chk("rb_addr",  w_addr, 16'h0000);
    #1 rst = 1'b0;
    mem_ready = 1'b0;
    tick();
    chk("rb_after_busy", w_busy, 1'b0);
    chk("rb_after_addr", w_addr, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
